alu_wide_sequencer: RTL and testbench
=====================================

// Module: alu_wide_sequencer
// PURPOSE
//  Runs multi-byte (8*BYTES-bit) arithmetic/logic ops on the shared 8-bit ALU, one byte per cycle.
//  Chains carry/borrow between bytes and returns the wide result plus wide-correct flags.
//  Sits between the CPU execute stage (start/done handshake) and the 8-bit ALU; sole ALU master while busy.
// PARAMETERS
//  BYTES  2  operand width in bytes; legal 2..4; W = 8*BYTES
// PORTS
//  clk           in   1   system clock; all state on posedge
//  rst           in   1   asynchronous, active-high reset
//  start         in   1   request; accepted only in IDLE
//  single        in   1   selects single-operand op group (same meaning as ALU single)
//  operator      in   4   `OP_* code from cpu_data.v
//  operand_a     in   W   first operand (value1 role)
//  operand_b     in   W   second operand (value2 role); ignored when single=1
//  carry_in      in   1   old carry for ADC/SBC/RLC/RRC
//  busy          out  1   high from accept until done cycle inclusive
//  done          out  1   one-cycle pulse; result/flags valid from this cycle
//  result        out  W   wide result; held until next non-CMP completion
//  flags         out  4   {carry, overflow, zero, negative}; held until next completion
//  unsupported   out  1   set with done when op has no wide mapping; result unchanged
//  alu_single    out  1   to ALU
//  alu_value1    out  8   to ALU
//  alu_value2    out  8   to ALU
//  alu_operator  out  4   to ALU
//  alu_old_carry out  1   to ALU
//  alu_bus_out   in   8   from ALU (registered; valid one cycle after inputs)
//  alu_flags     in   4   from ALU {c,v,z,n}; only c and v are used
// BEHAVIOUR
//  Reset: state IDLE, busy=0, done=0, unsupported=0, result=0, flags=0, ALU outputs 0, byte index 0.
//  FSM: IDLE -> ISSUE (BYTES cycles, one byte each) -> DRAIN (1 cycle) -> DONE (1 cycle, done=1) -> IDLE.
//  Latency: start accepted at edge N; done high in cycle N+BYTES+2. start while busy is ignored, not queued.
//  Byte order: LSB first for ADD/SUB/CMP/ADC/SBC/NEG/LSL/RLC; MSB first for LSR/RRC; logic ops LSB first.
//  Op mapping (first byte / later bytes):
//   ADD: ADD/ADC; SUB,CMP: SUB/SBC; ADC: ADC/ADC; SBC: SBC/SBC; AND,OR,XOR,MOV,COM: same op every byte.
//   NEG: issued as non-single SUB/SBC with value1=0, value2=byte. LSL: LSL/RLC. LSR: LSR/RRC. RLC,RRC: all bytes RLC/RRC.
//   ROL/ROR and unknown codes: no ALU cycles, go straight to DONE with unsupported=1, flags unchanged.
//  Carry chain: alu_old_carry = carry_in for first byte when op uses it, else ALU c captured from previous byte.
//   ALU result for byte k is captured one cycle after issue; DRAIN captures the last byte.
//  Flags: carry = c of last-issued byte (0 for logic ops); overflow = v of MSB byte;
//   zero = (wide result == 0), computed locally, ALU z ignored; negative = result[W-1].
//  CMP: flags updated, result register not written.
//  Reset mid-operation: immediate return to IDLE, partial result discarded, no done pulse.
// CONFIGURATION
//  ALU_WIDE_BYTE_MODE_EN defined: extra input byte_mode (1 bit, after carry_in); when 1 at start,
//   only byte 0 is issued (latency 3) and result upper bytes are zero-filled; flags from that byte.
//  Not defined: no byte_mode port; every op uses all BYTES bytes.
// STRUCTURE
//  `OP_* codes come from cpu_data.v; add shared `ALU_FLAG_C/V/Z/N bit indices there.
//  FSM state encodings are local.
//  One sub-module, alu_wide_opmap (combinational): operator+single+first-byte flag -> ALU op,
//   carry-source select, byte order, unsupported.
// TESTING
//  ADD 0x00FF + 0x0001 -> result 0x0100, c=0, z=0; ALU sees ADD then ADC with old_carry=1; done at N+4.
//  SUB 0x0000 - 0x0001 -> 0xFFFF, c=1, n=1; CMP same operands -> flags identical, result keeps prior value.
//  LSR single 0x8001 -> 0x4000, c=1, MSB byte issued first; LSL 0x8001 -> 0x0002, c=1.
//  NEG 0x0001 -> 0xFFFF; ADD 0x0000+0x0000 -> z=1; ROL -> unsupported=1 at N+1, result unchanged.
//  start pulsed while busy -> ignored; rst asserted mid-ISSUE -> busy=0 at once, no done, next op correct.
//  ALU_WIDE_BYTE_MODE_EN: byte_mode=1 ADD 0x12FF+0x1201 -> 0x0000, c=1, z=1, done at N+3.

Source files
------------

// File: rtl/alu_wide_sequencer_pkg.sv
// alu_wide_sequencer_pkg: CPU op codes, ALU flag bit indices and carry-source encoding shared by the wide sequencer.
package alu_wide_sequencer_pkg;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_ADC = 4'd2;
  localparam logic [3:0] OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
  localparam logic [3:0] OP_CMP = 4'd8;
  // Single-operand group: same code space, selected by the single bit.
  localparam logic [3:0] OP_COM = 4'd0;
  localparam logic [3:0] OP_NEG = 4'd1;
  localparam logic [3:0] OP_LSL = 4'd2;
  localparam logic [3:0] OP_LSR = 4'd3;
  localparam logic [3:0] OP_RLC = 4'd4;
  localparam logic [3:0] OP_RRC = 4'd5;
  localparam logic [3:0] OP_ROL = 4'd6;
  localparam logic [3:0] OP_ROR = 4'd7;
  localparam int ALU_FLAG_C = 3;
  localparam int ALU_FLAG_V = 2;
  localparam int ALU_FLAG_Z = 1;
  localparam int ALU_FLAG_N = 0;
  typedef enum logic [1:0] {CS_ZERO, CS_CIN, CS_CHAIN} carry_src_t;
endpackage

// File: rtl/alu_wide_opmap.sv
// alu_wide_opmap: maps a wide op and byte position to the 8-bit ALU op, carry source, byte order and support.
module alu_wide_opmap
  import alu_wide_sequencer_pkg::*;
(
  input  logic       single,
  input  logic [3:0] operator,
  input  logic       first,
  output logic [3:0] alu_op,
  output logic       alu_single,
  output logic [1:0] csrc,
  output logic       msb_first,
  output logic       neg,
  output logic       logic_op,
  output logic       cmp,
  output logic       unsupported
);
  logic [1:0] chain, seeded;
  assign chain = first ? CS_ZERO : CS_CHAIN;
  assign seeded = first ? CS_CIN : CS_CHAIN;
  always_comb begin
    alu_op = operator;
    alu_single = single;
    csrc = CS_ZERO;
    msb_first = 1'b0;
    neg = 1'b0;
    logic_op = 1'b0;
    cmp = 1'b0;
    unsupported = 1'b0;
    if (!single)
      case (operator)
        OP_ADD: begin alu_op = first ? OP_ADD : OP_ADC; csrc = chain; end
        OP_SUB, OP_CMP: begin alu_op = first ? OP_SUB : OP_SBC; csrc = chain; cmp = operator == OP_CMP; end
        OP_ADC, OP_SBC: csrc = seeded;
        OP_AND, OP_OR, OP_XOR, OP_MOV: logic_op = 1'b1;
        default: unsupported = 1'b1;
      endcase
    else
      case (operator)
        OP_COM: logic_op = 1'b1;
        OP_NEG: begin alu_op = first ? OP_SUB : OP_SBC; alu_single = 1'b0; csrc = chain; neg = 1'b1; end
        OP_LSL: begin alu_op = first ? OP_LSL : OP_RLC; csrc = chain; end
        OP_LSR: begin alu_op = first ? OP_LSR : OP_RRC; csrc = chain; msb_first = 1'b1; end
        OP_RLC: csrc = seeded;
        OP_RRC: begin csrc = seeded; msb_first = 1'b1; end
        default: unsupported = 1'b1;
      endcase
  end
endmodule

// File: rtl/alu_wide_sequencer.sv
// alu_wide_sequencer: runs 8*BYTES-bit ops one byte per cycle on the shared 8-bit ALU, chaining carry.
// Optional ALU_WIDE_BYTE_MODE_EN adds a byte_mode input that restricts an op to byte 0.
module alu_wide_sequencer
  import alu_wide_sequencer_pkg::*;
#(
  parameter int BYTES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 single,
  input  logic [3:0]           operator,
  input  logic [8*BYTES-1:0]   operand_a,
  input  logic [8*BYTES-1:0]   operand_b,
  input  logic                 carry_in,
`ifdef ALU_WIDE_BYTE_MODE_EN
  input  logic                 byte_mode,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [8*BYTES-1:0]   result,
  output logic [3:0]           flags,
  output logic                 unsupported,
  output logic                 alu_single,
  output logic [7:0]           alu_value1,
  output logic [7:0]           alu_value2,
  output logic [3:0]           alu_operator,
  output logic                 alu_old_carry,
  input  logic [7:0]           alu_bus_out,
  input  logic [3:0]           alu_flags
);
  localparam int W = 8 * BYTES;
  localparam logic [1:0] TOP = 2'(BYTES - 1);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  state_t state, state_nx;
  logic [3:0] op_r, m_op;
  logic single_r, cin_r, bm_r, bm_in, unsup_r, v_r, fin_v;
  logic m_single, m_msb_first, m_neg, m_logic, m_cmp, m_unsup;
  logic [1:0] m_csrc, idx, last, issue_pos, cap_idx, cap_pos;
  logic [W-1:0] a_r, b_r, acc, fin;
  logic [7:0] byte_a, byte_b;
  logic unused_flags;
`ifdef ALU_WIDE_BYTE_MODE_EN
  assign bm_in = byte_mode;
`else
  assign bm_in = 1'b0;
`endif
  assign unused_flags = ^alu_flags[ALU_FLAG_Z:ALU_FLAG_N];
  // In IDLE the map looks at the incoming request so unsupported ops can skip straight to DONE.
  alu_wide_opmap u_opmap (
    .single     (state == S_IDLE ? single : single_r),
    .operator   (state == S_IDLE ? operator : op_r),
    .first      (state == S_IDLE || idx == 2'd0),
    .alu_op     (m_op),
    .alu_single (m_single),
    .csrc       (m_csrc),
    .msb_first  (m_msb_first),
    .neg        (m_neg),
    .logic_op   (m_logic),
    .cmp        (m_cmp),
    .unsupported(m_unsup)
  );
  assign last = bm_r ? 2'd0 : TOP;
  assign issue_pos = m_msb_first && !bm_r ? TOP - idx : idx;
  assign cap_idx = state == S_DRAIN ? idx : idx - 2'd1;
  assign cap_pos = m_msb_first && !bm_r ? TOP - cap_idx : cap_idx;
  assign byte_a = 8'(a_r >> {issue_pos, 3'b000});
  assign byte_b = 8'(b_r >> {issue_pos, 3'b000});
  // Each byte slot of acc is written once, so OR-merging the returning byte is enough.
  assign fin = acc | (W'(alu_bus_out) << {cap_pos, 3'b000});
  assign fin_v = cap_pos == TOP || bm_r ? alu_flags[ALU_FLAG_V] : v_r;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  assign unsupported = done && unsup_r;
  assign alu_single = state == S_ISSUE && m_single;
  assign alu_operator = state == S_ISSUE ? m_op : 4'd0;
  assign alu_value1 = state == S_ISSUE && !m_neg ? byte_a : 8'd0;
  assign alu_value2 = state != S_ISSUE ? 8'd0 : m_neg ? byte_a : byte_b;
  assign alu_old_carry = state == S_ISSUE &&
                         (m_csrc == CS_CIN ? cin_r : m_csrc == CS_CHAIN && alu_flags[ALU_FLAG_C]);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: state_nx = !start ? S_IDLE : m_unsup ? S_DONE : S_ISSUE;
      S_ISSUE: state_nx = idx == last ? S_DRAIN : S_ISSUE;
      S_DRAIN: state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_r <= '0;
      single_r <= 1'b0;
      cin_r <= 1'b0;
      bm_r <= 1'b0;
      unsup_r <= 1'b0;
      v_r <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      idx <= '0;
      result <= '0;
      flags <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        op_r <= operator;
        single_r <= single;
        cin_r <= carry_in;
        bm_r <= bm_in;
        unsup_r <= m_unsup;
        v_r <= 1'b0;
        a_r <= operand_a;
        b_r <= operand_b;
        acc <= '0;
        idx <= '0;
      end
      if (state == S_ISSUE) begin
        if (idx != last) idx <= idx + 2'd1;
        if (idx != 2'd0) begin
          acc <= fin;
          if (cap_pos == TOP) v_r <= alu_flags[ALU_FLAG_V];
        end
      end
      if (state == S_DRAIN) begin
        if (!m_cmp) result <= fin;
        flags <= {!m_logic && alu_flags[ALU_FLAG_C], fin_v, fin == '0, bm_r ? fin[7] : fin[W-1]};
      end
    end
endmodule

// File: tb/tb_alu_wide_sequencer.sv
// tb_alu_wide_sequencer: drives alu_wide_sequencer against an 8-bit ALU model and a wide-arithmetic reference.
module tb_alu_wide_sequencer;
  import alu_wide_sequencer_pkg::*;
  localparam int BYTES = 2;
  localparam int W = 8 * BYTES;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, single = 1'b0, carry_in = 1'b0;
  logic [3:0] operator = 4'd0;
  logic [W-1:0] operand_a = '0, operand_b = '0;
`ifdef ALU_WIDE_BYTE_MODE_EN
  logic byte_mode = 1'b0;
`endif
  logic busy, done, unsupported, alu_single, alu_old_carry;
  logic [W-1:0] result;
  logic [3:0] flags, alu_operator, alu_flags;
  logic [7:0] alu_value1, alu_value2, alu_bus_out;
  int checks = 0, fails = 0;
  logic [W-1:0] exp_result = '0;
  logic [3:0] exp_flags = '0;
  logic [3:0] tr_op [0:15];
  logic [7:0] tr_v1 [0:15];
  logic tr_oc [0:15];

  alu_wide_sequencer #(.BYTES(BYTES)) dut (
    .clk(clk), .rst(rst), .start(start), .single(single), .operator(operator),
    .operand_a(operand_a), .operand_b(operand_b), .carry_in(carry_in),
`ifdef ALU_WIDE_BYTE_MODE_EN
    .byte_mode(byte_mode),
`endif
    .busy(busy), .done(done), .result(result), .flags(flags), .unsupported(unsupported),
    .alu_single(alu_single), .alu_value1(alu_value1), .alu_value2(alu_value2),
    .alu_operator(alu_operator), .alu_old_carry(alu_old_carry),
    .alu_bus_out(alu_bus_out), .alu_flags(alu_flags)
  );

  always #5 clk = ~clk;

  // Registered 8-bit ALU: returns {c, v, z, n, result}; carry on subtract is borrow.
  function automatic logic [11:0] alu8(input logic s, input logic [3:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input logic ci);
    logic [8:0] t;
    logic c, v;
    t = '0;
    c = 1'b0;
    v = 1'b0;
    if (!s)
      case (op)
        OP_ADD, OP_ADC: begin t = a + b + 9'(op == OP_ADC && ci); c = t[8]; v = a[7] == b[7] && t[7] != a[7]; end
        OP_SUB, OP_SBC, OP_CMP: begin t = a - b - 9'(op == OP_SBC && ci); c = t[8]; v = a[7] != b[7] && t[7] != a[7]; end
        OP_AND: t[7:0] = a & b;
        OP_OR: t[7:0] = a | b;
        OP_XOR: t[7:0] = a ^ b;
        OP_MOV: t[7:0] = b;
        default: ;
      endcase
    else
      case (op)
        OP_COM: t[7:0] = ~a;
        OP_LSL, OP_RLC: begin t[7:0] = {a[6:0], op == OP_RLC && ci}; c = a[7]; end
        OP_LSR, OP_RRC: begin t[7:0] = {op == OP_RRC && ci, a[7:1]}; c = a[0]; end
        default: ;
      endcase
    return {c, v, t[7:0] == 8'd0, t[7], t[7:0]};
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) {alu_flags, alu_bus_out} <= '0;
    else {alu_flags, alu_bus_out} <= alu8(alu_single, alu_operator, alu_value1, alu_value2, alu_old_carry);

  // Wide reference on n-bit operands using whole-word arithmetic.
  function automatic void ref_op(input logic s, input logic [3:0] op, input logic [31:0] a_in,
                                 input logic [31:0] b_in, input logic ci, input int n,
                                 output logic un, output logic cm, output logic [31:0] r, output logic [3:0] f);
    logic [32:0] a, b, t, m;
    logic c, v;
    int h;
    m = (33'd1 << n) - 33'd1;
    a = {1'b0, a_in} & m;
    b = {1'b0, b_in} & m;
    h = n - 1;
    t = '0;
    c = 1'b0;
    v = 1'b0;
    un = 1'b0;
    cm = 1'b0;
    if (!s)
      case (op)
        OP_ADD, OP_ADC: begin t = a + b + 33'(op == OP_ADC && ci); c = t[n]; v = a[h] == b[h] && t[h] != a[h]; end
        OP_SUB, OP_SBC, OP_CMP: begin
          t = a - b - 33'(op == OP_SBC && ci); c = t[n]; v = a[h] != b[h] && t[h] != a[h]; cm = op == OP_CMP;
        end
        OP_AND: t = a & b;
        OP_OR: t = a | b;
        OP_XOR: t = a ^ b;
        OP_MOV: t = b;
        default: un = 1'b1;
      endcase
    else
      case (op)
        OP_COM: t = ~a;
        OP_NEG: begin t = 33'd0 - a; c = a != 33'd0; v = a == (33'd1 << h); end
        OP_LSL: begin t = a << 1; c = a[h]; end
        OP_RLC: begin t = (a << 1) | 33'(ci); c = a[h]; end
        OP_LSR: begin t = a >> 1; c = a[0]; end
        OP_RRC: begin t = (a >> 1) | (33'(ci) << h); c = a[0]; end
        default: un = 1'b1;
      endcase
    r = 32'(t & m);
    f = {c, v, r == 32'd0, r[h]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input logic s, input logic [3:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic ci, input logic bm, input logic poke);
    logic un, cm;
    logic [31:0] r;
    logic [3:0] f;
    int k, lat;
    ref_op(s, op, 32'(a), 32'(b), ci, bm ? 8 : W, un, cm, r, f);
    lat = un ? 1 : (bm ? 1 : BYTES) + 2;
    @(negedge clk);
    single = s;
    operator = op;
    operand_a = a;
    operand_b = b;
    carry_in = ci;
`ifdef ALU_WIDE_BYTE_MODE_EN
    byte_mode = bm;
`endif
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      tr_op[k] = alu_operator;
      tr_v1[k] = alu_value1;
      tr_oc[k] = alu_old_carry;
      if (poke && k == 1) begin
        start = 1'b1;
        operand_a = ~a;
      end else start = 1'b0;
    end while (!done && k < 12);
    if (!un && !cm) exp_result = r[W-1:0];
    if (!un) exp_flags = f;
    chk({tag, " latency"}, k, lat);
    chk({tag, " result"}, result, exp_result);
    chk({tag, " flags"}, flags, exp_flags);
    chk({tag, " unsupported"}, unsupported, un);
    chk({tag, " busy at done"}, busy, 1);
    @(negedge clk);
    chk({tag, " idle after"}, {busy, done}, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset unsupported", unsupported, 0);
    chk("reset result", result, 0);
    chk("reset flags", flags, 0);
    chk("reset alu outputs", {alu_single, alu_operator, alu_value1, alu_value2, alu_old_carry}, 0);
    rst = 1'b0;
    run("add ff+1", 0, OP_ADD, 16'h00FF, 16'h0001, 0, 0, 0);
    chk("add ff+1 const result", result, 32'h0100);
    chk("add ff+1 const flags", flags, 4'b0000);
    chk("add byte0 op", tr_op[1], OP_ADD);
    chk("add byte0 value1", tr_v1[1], 8'hFF);
    chk("add byte1 op", tr_op[2], OP_ADC);
    chk("add byte1 old carry", tr_oc[2], 1);
    run("sub 0-1", 0, OP_SUB, 16'h0000, 16'h0001, 0, 0, 0);
    chk("sub const", {flags, result}, {4'b1001, 16'hFFFF});
    run("add 1234", 0, OP_ADD, 16'h1234, 16'h0000, 0, 0, 0);
    run("cmp 0-1", 0, OP_CMP, 16'h0000, 16'h0001, 0, 0, 0);
    chk("cmp const", {flags, result}, {4'b1001, 16'h1234});
    run("lsr 8001", 1, OP_LSR, 16'h8001, 16'h0000, 0, 0, 0);
    chk("lsr const", {flags, result}, {4'b1000, 16'h4000});
    chk("lsr byte0 is msb", tr_v1[1], 8'h80);
    chk("lsr ops", {tr_op[1], tr_op[2]}, {OP_LSR, OP_RRC});
    run("lsl 8001", 1, OP_LSL, 16'h8001, 16'h0000, 0, 0, 0);
    chk("lsl const", {flags, result}, {4'b1000, 16'h0002});
    run("neg 1", 1, OP_NEG, 16'h0001, 16'h0000, 0, 0, 0);
    chk("neg const", result, 16'hFFFF);
    run("neg 8000", 1, OP_NEG, 16'h8000, 16'h0000, 0, 0, 0);
    run("add 0+0", 0, OP_ADD, 16'h0000, 16'h0000, 0, 0, 0);
    chk("add zero flag", flags, 4'b0010);
    run("rol", 1, OP_ROL, 16'h1234, 16'h0000, 0, 0, 0);
    run("adc cin", 0, OP_ADC, 16'hFFFF, 16'h0000, 1, 0, 0);
    run("sbc cin", 0, OP_SBC, 16'h0100, 16'h0000, 1, 0, 0);
    run("rrc cin", 1, OP_RRC, 16'h0002, 16'h0000, 1, 0, 0);
    run("rlc cin", 1, OP_RLC, 16'h4000, 16'h0000, 1, 0, 0);
    run("add ovf", 0, OP_ADD, 16'h7FFF, 16'h0001, 0, 0, 0);
    run("poke busy", 0, OP_ADD, 16'h0102, 16'h0304, 0, 0, 1);
    @(negedge clk);
    single = 1'b0;
    operator = OP_ADD;
    operand_a = 16'h1111;
    operand_b = 16'h2222;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("rst mid busy before", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst mid busy", busy, 0);
    chk("rst mid done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_result = '0;
    exp_flags = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst no done", {busy, done}, 0);
    end
    chk("rst result cleared", result, 0);
    run("after rst", 0, OP_SUB, 16'h5000, 16'h1000, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      logic s;
      logic [3:0] op;
      logic [W-1:0] a;
      s = 1'($urandom_range(0, 1));
      op = 4'($urandom_range(0, s ? 7 : 9));
      a = i % 5 == 0 ? 16'h8000 : i % 7 == 0 ? 16'hFFFF : W'($urandom);
      run("random", s, op, a, W'($urandom), 1'($urandom), 0, 0);
    end
`ifdef ALU_WIDE_BYTE_MODE_EN
    run("byte mode add", 0, OP_ADD, 16'h12FF, 16'h1201, 0, 1, 0);
    chk("byte mode const", {flags, result}, {4'b1010, 16'h0000});
    for (int i = 0; i < 10; i++)
      run("byte mode random", 0, 4'($urandom_range(0, 8)), W'($urandom), W'($urandom), 1'($urandom), 1, 0);
`endif
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
